// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset processor.
// Covers the opcodes, FSM states, ALU operations and immediate formats.
package cpu_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_fmt_t;

    // R-type and I-ALU share this funct3 mapping; only R-type may select SUB.
    function automatic alu_op_t funct3_op(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b001:  return ALU_SLL;
            3'b101:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] make_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        case (fmt)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU shared by arithmetic, LUI and load/store address generation.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK around one ALU.
// Instruction and data memories, register file and control all live here.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_INIT  = ""
) (
    input logic clk,
    input logic rst
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0] pc, ir, old_pc_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];
    state_t      state, state_next;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        legal, use_imm, taken;
    imm_fmt_t    fmt;
    alu_op_t     alu_op;
    logic [31:0] imm, alu_b, alu_result;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    always_comb begin
        legal   = 1'b0;
        use_imm = 1'b0;
        fmt     = IMM_I;
        alu_op  = ALU_ADD;
        case (opcode)
            OP_R: begin
                legal  = (funct3 != 3'b011) &&
                         ((funct7 == 7'b0) || (funct7 == 7'b0100000 && funct3 == 3'b000));
                alu_op = funct3_op(funct3, funct7[5]);
            end
            OP_I: begin
                legal   = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
                alu_op  = funct3_op(funct3, 1'b0);
                use_imm = 1'b1;
            end
            OP_LW: begin
                legal   = (funct3 == 3'b010);
                use_imm = 1'b1;
            end
            OP_SW: begin
                legal   = (funct3 == 3'b010);
                use_imm = 1'b1;
                fmt     = IMM_S;
            end
            OP_BR: begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                fmt   = IMM_B;
            end
            OP_JAL: begin
                legal = 1'b1;
                fmt   = IMM_J;
            end
            OP_LUI: begin
                legal   = 1'b1;
                use_imm = 1'b1;
                fmt     = IMM_U;
                alu_op  = ALU_PASSB;
            end
            default: ;
        endcase
    end

    assign imm   = make_imm(ir, fmt);
    assign alu_b = use_imm ? imm : b_reg;
    assign taken = funct3[0] ? (a_reg != b_reg) : (a_reg == b_reg);

    cpu_alu u_alu (
        .a      (a_reg),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = legal ? EXECUTE : FETCH;
            EXECUTE: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI: state_next = WRITEBACK;
                    OP_LW, OP_SW:       state_next = MEMORY;
                    default:            state_next = FETCH;
                endcase
            end
            MEMORY:    state_next = (opcode == OP_LW) ? WRITEBACK : FETCH;
            WRITEBACK: state_next = FETCH;
            default:   state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= '0;
            ir          <= '0;
            old_pc_reg  <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir         <= imem[pc[IW+1:2]];
                    old_pc_reg <= pc;
                    pc         <= pc + 32'd4;
                end
                DECODE: begin
                    a_reg <= regs[rs1];
                    b_reg <= regs[rs2];
                end
                EXECUTE: begin
                    case (opcode)
                        OP_BR: if (taken) pc <= old_pc_reg + imm;
                        OP_JAL: begin
                            if (rd != 5'd0) regs[rd] <= old_pc_reg + 32'd4;
                            pc <= old_pc_reg + imm;
                        end
                        default: alu_out_reg <= alu_result;
                    endcase
                end
                MEMORY: if (opcode == OP_LW) mdr_reg <= dmem[alu_out_reg[DW+1:2]];
                WRITEBACK: if (rd != 5'd0) regs[rd] <= (opcode == OP_LW) ? mdr_reg : alu_out_reg;
                default: ;
            endcase
        end
    end

    // Reset forces state to FETCH immediately, so an aborted store can never land.
    always_ff @(posedge clk) begin
        if (state == MEMORY && opcode == OP_SW) dmem[alu_out_reg[DW+1:2]] <= b_reg;
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Program-level bench for multicycle_cpu: loads small programs through the memory
// arrays, queues expected architectural state and compares it after a fixed cycle count.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    typedef enum int {K_REG, K_DMEM, K_PC, K_STATE, K_IR, K_REGS_OR} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog_q[$];

    multicycle_cpu #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .IMEM_INIT  ("")
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic expect_val(input string tag, input kind_t kind, input int idx, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.idx   = idx;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] obs;
            e   = sb.pop_front();
            obs = '0;
            case (e.kind)
                K_REG:   obs = dut.regs[e.idx];
                K_DMEM:  obs = dut.dmem[e.idx];
                K_PC:    obs = dut.pc;
                K_STATE: obs = 32'(dut.state);
                K_IR:    obs = dut.ir;
                default: for (int i = 0; i < 32; i++) obs = obs | dut.regs[i];
            endcase
            check_value(e.tag, obs, e.value);
        end
    endtask

    // Holds reset, loads prog_q into a zeroed imem, zeroes dmem, then releases.
    task automatic start_program();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dut.imem[i] = '0;
            dut.dmem[i] = '0;
        end
        for (int i = 0; i < prog_q.size(); i++) dut.imem[i] = prog_q[i];
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        expect_val("reset_pc", K_PC, 0, 32'h0);
        expect_val("reset_ir", K_IR, 0, 32'h0);
        expect_val("reset_state", K_STATE, 0, 32'(FETCH));
        expect_val("reset_regs", K_REGS_OR, 0, 32'h0);
        drain();

        // Basic program: ADDI, ADDI, ADD, SW, LW
        prog_q = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00302023, 32'h00002203};
        start_program();
        run(21);
        expect_val("basic_x1", K_REG, 1, 32'd5);
        expect_val("basic_x2", K_REG, 2, 32'd10);
        expect_val("basic_x3", K_REG, 3, 32'd15);
        expect_val("basic_dmem0", K_DMEM, 0, 32'd15);
        expect_val("basic_x4", K_REG, 4, 32'd15);
        expect_val("basic_pc", K_PC, 0, 32'h14);
        drain();

        // Taken BEQ skips one ADDI and costs 3 cycles
        prog_q = '{32'h00300093, 32'h00108463, 32'h00100113, 32'h00700193};
        start_program();
        run(7);
        expect_val("beq_pc_after_3", K_PC, 0, 32'd12);
        expect_val("beq_state", K_STATE, 0, 32'(FETCH));
        drain();
        run(4);
        expect_val("beq_x2_skipped", K_REG, 2, 32'd0);
        expect_val("beq_x3", K_REG, 3, 32'd7);
        expect_val("beq_pc_end", K_PC, 0, 32'd16);
        drain();

        // BNE with equal operands falls through
        prog_q = '{32'h00300093, 32'h00109463, 32'h00100113};
        start_program();
        run(7);
        expect_val("bne_pc_fall", K_PC, 0, 32'd8);
        drain();
        run(4);
        expect_val("bne_x2", K_REG, 2, 32'd1);
        drain();

        // JAL x5,+12 then a write to x0
        prog_q = '{32'h00c002ef, 32'h00100313, 32'h00100313, 32'h00900013};
        start_program();
        run(3);
        expect_val("jal_x5", K_REG, 5, 32'd4);
        expect_val("jal_pc", K_PC, 0, 32'd12);
        drain();
        run(4);
        expect_val("jal_x6_skipped", K_REG, 6, 32'd0);
        expect_val("x0_stays_zero", K_REG, 0, 32'd0);
        expect_val("jal_pc_end", K_PC, 0, 32'd16);
        drain();

        // Signed ops and LUI
        prog_q = '{32'hfff00093, 32'h0000a133, 32'h123451b7};
        start_program();
        run(12);
        expect_val("neg_x1", K_REG, 1, 32'hffffffff);
        expect_val("slt_x2", K_REG, 2, 32'd1);
        expect_val("lui_x3", K_REG, 3, 32'h12345000);
        drain();

        // Reset in the MEMORY state of SW x1,8(x0)
        prog_q = '{32'h02a00093, 32'h00102423};
        start_program();
        run(7);
        expect_val("sw_in_memory", K_STATE, 0, 32'(MEMORY));
        drain();
        rst = 1'b0;
        #1;
        expect_val("abort_pc", K_PC, 0, 32'd0);
        expect_val("abort_state", K_STATE, 0, 32'(FETCH));
        expect_val("abort_regs", K_REGS_OR, 0, 32'h0);
        drain();
        run(2);
        expect_val("abort_dmem2", K_DMEM, 2, 32'h0);
        drain();
        rst = 1'b1;
        run(4);
        expect_val("restart_x1", K_REG, 1, 32'd42);
        expect_val("restart_pc", K_PC, 0, 32'd4);
        drain();
        run(4);
        expect_val("restart_sw_dmem2", K_DMEM, 2, 32'd42);
        drain();

        // Unsupported opcode acts as a 2-cycle NOP
        prog_q = '{32'hffffffff};
        start_program();
        dut.dmem[0] = 32'h00001234;
        run(2);
        expect_val("nop_pc", K_PC, 0, 32'd4);
        expect_val("nop_state", K_STATE, 0, 32'(FETCH));
        expect_val("nop_regs", K_REGS_OR, 0, 32'h0);
        expect_val("nop_dmem0", K_DMEM, 0, 32'h00001234);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
